fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the word width; it SHALL match the attached FIFO.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning the burst length field width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  burst request; sampled only in IDLE.
REQ-006 len  input  LEN_WIDTH  burst length in words; sampled with start.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_data  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
REQ-009 fifo_rd_en  output  1  FIFO read strobe, combinational from registered state and fifo_empty.
REQ-010 m_valid  output  1  output word valid.
REQ-011 m_data  output  DATA_WIDTH  output word.
REQ-012 m_last  output  1  marks the final word of the burst; qualified by m_valid.
REQ-013 m_ready  input  1  downstream accept.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  single-cycle pulse at burst completion.

Function
REQ-016 A read SHALL be accepted in the cycle where fifo_rd_en=1 and fifo_empty=0.
REQ-017 The corresponding word SHALL be captured from fifo_data on the next rising edge.
REQ-018 A transfer SHALL occur on any edge where m_valid=1 and m_ready=1.
REQ-019 The block SHALL buffer output words in a 2-entry FIFO-ordered skid buffer; m_valid/m_data/m_last SHALL come from the buffer head.
REQ-020 Credit rule: fifo_rd_en = (state==FETCH) && !fifo_empty && (issued < len_q) && (occ + inflight - pop < 2).
  - occ = buffered entries (0..2); inflight = read accepted last cycle (0/1); pop = transfer this cycle.
REQ-021 The buffer SHALL never overflow; a captured word SHALL never be dropped or duplicated.
REQ-022 Throughput SHALL be one word per cycle while the FIFO is non-empty and m_ready=1.
REQ-023 Latency from the first accepted read to m_valid=1 SHALL be 2 edges.
REQ-024 State IDLE: on start=1, len_q<=len, issued<=0, sent<=0.
  - len!=0: go to FETCH.
  - len==0: go to DONE.
REQ-025 State FETCH: issued SHALL increment on each accepted read; when issued reaches len_q, go to DRAIN.
REQ-026 State DRAIN: no reads; when sent==len_q (last word transferred) go to DONE.
REQ-027 State DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-028 sent SHALL increment per transfer; m_last=1 when the head word is word index len_q-1.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 If fifo_empty stays high, FETCH SHALL wait indefinitely with no timeout.
REQ-031 m_ready=0 SHALL stall the head while holding m_data/m_last stable with m_valid held high.
REQ-032 issued and sent SHALL be LEN_WIDTH bits; len = 2^LEN_WIDTH-1 (255) SHALL complete without wrap.

Reset
REQ-033 While rst=0: state=IDLE; occ, inflight, issued, sent = 0; fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
REQ-034 Reset asserted mid-burst SHALL discard the buffered and in-flight words.
REQ-035 After reset release, no read or transfer SHALL occur until a new start.

Verification
REQ-036 FIFO preloaded 0x11..0x14, start len=4, m_ready=1 -> 4 reads on consecutive cycles; m_data 0x11,0x12,0x13,0x14 on consecutive cycles; m_last only on 0x14; done one cycle after that transfer.
REQ-037 len=4, m_ready=0 for 10 cycles then 1 -> exactly 2 reads before the stall; m_valid held with m_data=0x11; all 4 words delivered in order; no loss.
REQ-038 FIFO empty at start, len=3, words pushed one every 5 cycles -> fifo_rd_en only when fifo_empty=0; 3 transfers; then done.
REQ-039 start len=0 -> busy for 1 cycle, done pulse, fifo_rd_en never asserted.
REQ-040 rst=0 asserted after 2 of 5 words transferred -> all outputs at reset values immediately; new start len=1 then reads the next FIFO word correctly.
REQ-041 m_ready toggling 1/0 each cycle, len=255 -> 255 transfers in order, m_last on the 255th, issued never exceeds 255.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: burst control,
// FIFO read port and the output stream.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output start, len, fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        input  start, len, fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Reads a burst of len words from a FIFO and streams them out
// through a 2-entry skid buffer with credit-based read issue.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    fifo_burst_reader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t                state;
    state_t                state_nx;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  sent;
    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  m_valid;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            credit;
    logic [2:0]            limit;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && bus.m_ready;

    // Words already owned (buffered + in flight) must leave room
    // for the new read once this cycle's pop is accounted for.
    assign credit = {1'b0, occ} + {2'b00, inflight};
    assign limit  = 3'd2 + {2'b00, pop};

    assign rd_en = (state == FETCH) && !bus.fifo_empty &&
                   (issued < len_q) && (credit < limit);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (rd_en && (issued == len_q - ONE)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (sent == len_q - ONE)) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            sent     <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            state    <= state_nx;
            inflight <= rd_en;
            if (state == IDLE && bus.start) begin
                len_q  <= bus.len;
                issued <= '0;
                sent   <= '0;
            end else begin
                if (rd_en) issued <= issued + ONE;
                if (pop)   sent   <= sent + ONE;
            end
            if (inflight) begin
                mem[wr_ptr] <= bus.fifo_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = mem[rd_ptr];
    assign bus.m_last     = m_valid && (sent == len_q - ONE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: vector table, hand
// sequences for reset mid-burst, and randomized bursts.
module tb_fifo_burst_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

    fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int lenv;
        int pre;
        int gap;
        int extra;
        int rmode;
        int exp_busy;
        int exp_pre;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] fq [$];
    int         nvec = 0;
    int         nmis = 0;

    logic       s_rd, s_emp, s_mv, s_mr, s_ml, s_done, s_busy;
    logic [7:0] s_md;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint exp);
        nvec++;
        if (!ok) begin
            nmis++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {bus.fifo_rd_en, bus.m_valid, bus.m_data,
                bus.m_last, bus.busy, bus.done};
    endfunction

    // Called just after a falling edge; samples, clocks, then
    // serves the FIFO read accepted in the sampled cycle.
    task automatic step();
        #2;
        s_rd   = bus.fifo_rd_en;
        s_emp  = bus.fifo_empty;
        s_mv   = bus.m_valid;
        s_md   = bus.m_data;
        s_ml   = bus.m_last;
        s_mr   = bus.m_ready;
        s_done = bus.done;
        s_busy = bus.busy;
        @(posedge clk);
        #1;
        if (s_rd && !s_emp && fq.size() > 0)
            bus.fifo_data = fq.pop_front();
        bus.fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic run_burst(input vec_t v, input bit keep);
        logic [7:0] words [$];
        int cyc = 0, reads = 0, xfers = 0, busy_cnt = 0, done_cnt = 0;
        int first_read = -1, first_xfer = -1, last_xfer = -1;
        int pre_reads = -1, nxt = 0;
        bit prev_stall = 0;
        logic [7:0] prev_md = '0;
        logic prev_ml = 0;
        if (keep) begin
            words = fq;
            nxt = words.size();
        end else begin
            fq.delete();
            for (int i = 0; i < v.lenv + v.extra; i++)
                words.push_back(8'($urandom));
            for (int i = 0; i < v.pre && i < words.size(); i++)
                fq.push_back(words[i]);
            nxt = (v.pre < words.size()) ? v.pre : words.size();
        end
        bus.fifo_empty = (fq.size() == 0);
        bus.len = 8'(v.lenv);
        bus.start = 1'b1;
        while (done_cnt == 0 && cyc < 3000) begin
            if (cyc == 1) bus.start = 1'b0;
            if (v.rmode == 3 && cyc == 3) begin
                bus.start = 1'b1;
                bus.len = 8'd1;
            end
            if (v.rmode == 3 && cyc == 4) bus.start = 1'b0;
            case (v.rmode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = (cyc % 2 == 0);
                2: bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = (cyc >= 10);
            endcase
            if (v.gap > 0 && cyc > 0 && cyc % v.gap == 0 &&
                nxt < words.size()) begin
                fq.push_back(words[nxt]);
                nxt++;
                bus.fifo_empty = 1'b0;
            end
            step();
            check(!(s_rd && s_emp), "rd_when_empty", s_rd, 0);
            if (prev_stall)
                check(s_mv && s_md == prev_md && s_ml == prev_ml,
                      "stall_hold", s_md, prev_md);
            if (s_mv && s_mr) begin
                if (first_xfer < 0) begin
                    first_xfer = cyc;
                    pre_reads = reads;
                end
                last_xfer = cyc;
                if (xfers < words.size())
                    check(s_md == words[xfers], "data", s_md, words[xfers]);
                else
                    check(0, "extra_xfer", xfers, v.lenv);
                check(s_ml == (xfers == v.lenv - 1), "last", s_ml,
                      xfers == v.lenv - 1);
                xfers++;
            end
            if (s_rd && !s_emp) begin
                reads++;
                if (first_read < 0) first_read = cyc;
            end
            check(reads <= v.lenv, "over_read", reads, v.lenv);
            check(reads - xfers <= 2, "occupancy", reads - xfers, 2);
            if (s_busy) busy_cnt++;
            if (s_done) done_cnt++;
            prev_stall = s_mv && !s_mr;
            prev_md = s_md;
            prev_ml = s_ml;
            cyc++;
        end
        check(done_cnt == 1, "done_seen", done_cnt, 1);
        bus.m_ready = 1'b1;
        step();
        check(!s_done && !s_busy && !s_rd, "post_done_idle",
              {s_done, s_busy, s_rd}, 0);
        check(xfers == v.lenv, "xfer_count", xfers, v.lenv);
        check(reads == v.lenv, "read_count", reads, v.lenv);
        if (v.exp_busy >= 0)
            check(busy_cnt == v.exp_busy, "busy_cycles",
                  busy_cnt, v.exp_busy);
        if (v.exp_pre >= 0)
            check(pre_reads == v.exp_pre, "reads_before_xfer",
                  pre_reads, v.exp_pre);
        if (v.rmode == 0 && v.gap == 0 && v.lenv > 0 &&
            words.size() >= v.lenv) begin
            check(first_xfer - first_read == 2, "latency",
                  first_xfer - first_read, 2);
            check(last_xfer - first_xfer == v.lenv - 1, "throughput",
                  last_xfer - first_xfer, v.lenv - 1);
        end
    endtask

    initial begin
        int xf, k;
        vec_t rv;
        tbl[0] = '{4,   4,   0, 0, 0, 7,   -1};
        tbl[1] = '{4,   4,   0, 2, 3, -1,  2};
        tbl[2] = '{3,   0,   5, 0, 0, -1,  -1};
        tbl[3] = '{0,   2,   0, 2, 0, 1,   -1};
        tbl[4] = '{1,   3,   0, 2, 0, 4,   -1};
        tbl[5] = '{255, 255, 0, 0, 1, -1,  -1};
        tbl[6] = '{255, 255, 0, 1, 0, 258, -1};
        tbl[7] = '{8,   2,   3, 0, 2, -1,  -1};

        rst = 1'b0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data = '0;
        bus.m_ready = 1'b0;
        #3;
        check(outs() == 13'd0, "reset_state", outs(), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_burst(tbl[i], 1'b0);

        fq.delete();
        for (int i = 0; i < 5; i++) fq.push_back(8'(8'h21 + i));
        bus.fifo_empty = 1'b0;
        bus.len = 8'd5;
        bus.start = 1'b1;
        bus.m_ready = 1'b1;
        step();
        bus.start = 1'b0;
        xf = 0;
        k = 0;
        while (xf < 2 && k < 50) begin
            step();
            if (s_mv && s_mr) begin
                check(s_md == 8'(8'h21 + xf), "rst_pre_data",
                      s_md, 8'h21 + xf);
                xf++;
            end
            k++;
        end
        check(xf == 2, "rst_pre_xfers", xf, 2);
        rst = 1'b0;
        #1;
        check(outs() == 13'd0, "rst_mid_burst", outs(), 0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check(!s_rd && !s_mv && !s_busy, "post_rst_quiet",
                  {s_rd, s_mv, s_busy}, 0);
        end
        check(fq.size() == 1, "rst_fifo_left", fq.size(), 1);
        rv = '{1, 0, 0, 0, 0, 4, -1};
        run_burst(rv, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rv.lenv = $urandom_range(0, 20);
            rv.extra = $urandom_range(0, 2);
            rv.gap = $urandom_range(0, 4);
            rv.pre = (rv.gap == 0) ? rv.lenv + rv.extra
                                   : $urandom_range(0, rv.lenv);
            rv.rmode = 2;
            rv.exp_busy = -1;
            rv.exp_pre = -1;
            run_burst(rv, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
